// File: rtl/cpu_sequencer.sv
// ---------------------------------------------------------------------------
// cpu_sequencer
//   Microsequencer that produces the control address register (CAR) walked by
//   the CPU control unit. At fetch (CAR_0) the incoming instruction word is
//   decoded into the first state of its micro-sequence. Each chain then steps
//   through consecutive CAR encodings until it reaches its terminal state. The
//   interrupt micro-sequence is inserted only at instruction boundaries.
//
// Ports
//   MCLK       in   1         CPU clock, rising edge
//   reset_n    in   1         asynchronous active-low reset
//   MDBin      in   16        instruction word being latched into IR
//   IR         in   16        current instruction register
//   N,Z,C,V    in   1 each    status flags for conditional jumps
//   INTREQ     in   1         masked interrupt request (level)
//   HOLD       in   1         memory stall; freezes the sequencer
//   CAR        out  CAR_BITS  current control address (registered)
//   IRload     out  1         IR write strobe, fetch state and not stalled
//   InstrDone  out  1         last cycle of an instruction sequence, not stalled
// ---------------------------------------------------------------------------
module cpu_sequencer #(
    parameter int CAR_BITS = 6
) (
    input  logic                MCLK,
    input  logic                reset_n,
    input  logic [15:0]         MDBin,
    input  logic [15:0]         IR,
    input  logic                N,
    input  logic                Z,
    input  logic                C,
    input  logic                V,
    input  logic                INTREQ,
    input  logic                HOLD,
    output logic [CAR_BITS-1:0] CAR,
    output logic                IRload,
    output logic                InstrDone
);

    // Every chain occupies consecutive encodings so a step is CAR+1.
    localparam logic [CAR_BITS-1:0] CAR_0        = CAR_BITS'(0);
    localparam logic [CAR_BITS-1:0] CAR_REG_REG  = CAR_BITS'(1);
    localparam logic [CAR_BITS-1:0] CAR_REG_IDX0 = CAR_BITS'(2);
    localparam logic [CAR_BITS-1:0] CAR_REG_IDX3 = CAR_BITS'(5);
    localparam logic [CAR_BITS-1:0] CAR_IND_REG0 = CAR_BITS'(6);
    localparam logic [CAR_BITS-1:0] CAR_IND_REG1 = CAR_BITS'(7);
    localparam logic [CAR_BITS-1:0] CAR_IND_IDX0 = CAR_BITS'(8);
    localparam logic [CAR_BITS-1:0] CAR_IND_IDX4 = CAR_BITS'(12);
    localparam logic [CAR_BITS-1:0] CAR_IDX_REG0 = CAR_BITS'(13);
    localparam logic [CAR_BITS-1:0] CAR_IDX_REG2 = CAR_BITS'(15);
    localparam logic [CAR_BITS-1:0] CAR_IDX_IDX0 = CAR_BITS'(16);
    localparam logic [CAR_BITS-1:0] CAR_IDX_IDX5 = CAR_BITS'(21);
    localparam logic [CAR_BITS-1:0] CAR_1OP_REG  = CAR_BITS'(22);
    localparam logic [CAR_BITS-1:0] CAR_1OP_IND0 = CAR_BITS'(23);
    localparam logic [CAR_BITS-1:0] CAR_1OP_IND2 = CAR_BITS'(25);
    localparam logic [CAR_BITS-1:0] CAR_1OP_IDX0 = CAR_BITS'(26);
    localparam logic [CAR_BITS-1:0] CAR_1OP_IDX3 = CAR_BITS'(29);
    localparam logic [CAR_BITS-1:0] CAR_PUSH_REG0 = CAR_BITS'(30);
    localparam logic [CAR_BITS-1:0] CAR_PUSH_REG2 = CAR_BITS'(32);
    localparam logic [CAR_BITS-1:0] CAR_PUSH_IND0 = CAR_BITS'(33);
    localparam logic [CAR_BITS-1:0] CAR_PUSH_IND2 = CAR_BITS'(35);
    localparam logic [CAR_BITS-1:0] CAR_PUSH_IDX0 = CAR_BITS'(36);
    localparam logic [CAR_BITS-1:0] CAR_PUSH_IDX3 = CAR_BITS'(39);
    localparam logic [CAR_BITS-1:0] CAR_CALL_REG0 = CAR_BITS'(40);
    localparam logic [CAR_BITS-1:0] CAR_CALL_REG2 = CAR_BITS'(42);
    localparam logic [CAR_BITS-1:0] CAR_CALL_IND0 = CAR_BITS'(43);
    localparam logic [CAR_BITS-1:0] CAR_CALL_IND2 = CAR_BITS'(45);
    localparam logic [CAR_BITS-1:0] CAR_CALL_IDX0 = CAR_BITS'(46);
    localparam logic [CAR_BITS-1:0] CAR_CALL_IDX3 = CAR_BITS'(49);
    localparam logic [CAR_BITS-1:0] CAR_RETI0    = CAR_BITS'(50);
    localparam logic [CAR_BITS-1:0] CAR_RETI3    = CAR_BITS'(53);
    localparam logic [CAR_BITS-1:0] CAR_JMP0     = CAR_BITS'(54);
    localparam logic [CAR_BITS-1:0] CAR_INT0     = CAR_BITS'(55);
    localparam logic [CAR_BITS-1:0] CAR_INT4     = CAR_BITS'(59);

    localparam logic [1:0] M_REG = 2'd0;
    localparam logic [1:0] M_IDX = 2'd1;
    localparam logic [1:0] M_IND = 2'd2;

    logic [CAR_BITS-1:0] r_car;
    logic [CAR_BITS-1:0] w_next;
    logic [CAR_BITS-1:0] w_dec;
    logic                w_term;
    logic                w_unused;

    // IR contents and the byte/word bit do not influence sequencing.
    assign w_unused = ^{IR, MDBin[6]};

    // Addressing mode with the constant-generator cases folded onto REG:
    // R3 always generates a constant, R2 does for As=1x; R2 with As=01 is
    // absolute addressing and stays on the indexed path.
    function automatic logic [1:0] f_mode(input logic [1:0] as, input logic [3:0] rg);
        if (rg == 4'd3 || (rg == 4'd2 && as[1]))
            return M_REG;
        case (as)
            2'b00:   return M_REG;
            2'b01:   return M_IDX;
            default: return M_IND;
        endcase
    endfunction

    function automatic logic f_is_term(input logic [CAR_BITS-1:0] car);
        case (car)
            CAR_REG_REG, CAR_REG_IDX3, CAR_IND_REG1, CAR_IND_IDX4,
            CAR_IDX_REG2, CAR_IDX_IDX5, CAR_1OP_REG, CAR_1OP_IND2,
            CAR_1OP_IDX3, CAR_PUSH_REG2, CAR_PUSH_IND2, CAR_PUSH_IDX3,
            CAR_CALL_REG2, CAR_CALL_IND2, CAR_CALL_IDX3, CAR_RETI3,
            CAR_JMP0: return 1'b1;
            default:  return 1'b0;
        endcase
    endfunction

    function automatic logic [CAR_BITS-1:0] f_decode(
        input logic [15:0] w,
        input logic n, input logic z, input logic c, input logic v);
        logic       taken;
        logic [1:0] md;
        if (w[15:12] == 4'd0) begin
            return CAR_0;
        end else if (w[15:13] == 3'b001) begin
            case (w[12:10])
                3'b000:  taken = ~z;
                3'b001:  taken = z;
                3'b010:  taken = ~c;
                3'b011:  taken = c;
                3'b100:  taken = n;
                3'b101:  taken = ~(n ^ v);
                3'b110:  taken = n ^ v;
                default: taken = 1'b1;
            endcase
            return taken ? CAR_JMP0 : CAR_0;
        end else if (w[15:12] == 4'b0001) begin
            md = f_mode(w[5:4], w[3:0]);
            case (w[9:7])
                3'b000, 3'b001, 3'b010, 3'b011:
                    return (md == M_REG) ? CAR_1OP_REG :
                           (md == M_IDX) ? CAR_1OP_IDX0 : CAR_1OP_IND0;
                3'b100:
                    return (md == M_REG) ? CAR_PUSH_REG0 :
                           (md == M_IDX) ? CAR_PUSH_IDX0 : CAR_PUSH_IND0;
                3'b101:
                    return (md == M_REG) ? CAR_CALL_REG0 :
                           (md == M_IDX) ? CAR_CALL_IDX0 : CAR_CALL_IND0;
                3'b110:  return CAR_RETI0;
                default: return CAR_0;
            endcase
        end else begin
            md = f_mode(w[5:4], w[11:8]);
            case (md)
                M_REG:   return w[7] ? CAR_REG_IDX0 : CAR_REG_REG;
                M_IDX:   return w[7] ? CAR_IDX_IDX0 : CAR_IDX_REG0;
                default: return w[7] ? CAR_IND_IDX0 : CAR_IND_REG0;
            endcase
        end
    endfunction

    always_ff @(posedge MCLK or negedge reset_n) begin
        if (!reset_n)
            r_car <= CAR_0;
        else
            r_car <= w_next;
    end

    always_comb begin
        w_next = r_car;
        w_term = f_is_term(r_car);
        w_dec  = f_decode(MDBin, N, Z, C, V);
        if (HOLD) begin
            w_next = r_car;
        end else if (r_car == CAR_0) begin
            // A fetch that yields no sequence (NOP, untaken jump) is itself
            // an instruction boundary.
            w_next = (w_dec == CAR_0 && INTREQ) ? CAR_INT0 : w_dec;
        end else if (w_term) begin
            w_next = INTREQ ? CAR_INT0 : CAR_0;
        end else if (r_car >= CAR_INT4) begin
            // INT4 always returns to fetch; unused encodings recover there too.
            w_next = CAR_0;
        end else begin
            w_next = r_car + CAR_BITS'(1);
        end
    end

    assign CAR       = r_car;
    assign IRload    = (r_car == CAR_0) & ~HOLD;
    assign InstrDone = w_term & ~HOLD;

endmodule
